// File: rtl/hex_display_if.sv
// Avalon-MM slave bus bundle for the seven-segment display controller.
// Readdata is combinational in the slave, so there is no read strobe.
interface hex_display_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: per-digit raw/hex-decode mode, per-digit blink
// driven by a programmable half-period divider, and a registered polarity-adjusted pin bus.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_W    = 26,
    parameter int BLINK_RST  = 25000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hex_display_if.slave            bus,
    output logic [NUM_DIGITS*7-1:0] out_port
);

    localparam int OUT_W = NUM_DIGITS * 7;
    // XOR mask turning logical segments into pin levels; also the all-off pin pattern.
    localparam logic [OUT_W-1:0] PIN_OFF = {OUT_W{ACTIVE_LOW != 0}};

    logic [NUM_DIGITS-1:0]   mode;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [4*NUM_DIGITS-1:0] hexval;
    logic [6:0]              raw [NUM_DIGITS];
    logic [BLINK_W-1:0]      blink_div;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    phase;
    logic [OUT_W-1:0]        seg_p0;
    logic [31:0]             rd_data;
    logic                    wr_en;
    logic                    div_wr;
    logic                    unused_wdata;

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign div_wr       = wr_en && (bus.address == 4'd2);
    assign unused_wdata = ^bus.writedata;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode     <= '0;
            blink_en <= '0;
            hexval   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) raw[i] <= '0;
        end else if (wr_en) begin
            case (bus.address)
                4'd0: begin
                    mode     <= bus.writedata[NUM_DIGITS-1:0];
                    blink_en <= bus.writedata[8 +: NUM_DIGITS];
                end
                4'd1: hexval <= bus.writedata[4*NUM_DIGITS-1:0];
                default: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (bus.address == 4'(8 + i)) raw[i] <= bus.writedata[6:0];
                end
            endcase
        end
    end

    // A divider write restarts the half-period even if it lands on a wrap edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_div <= BLINK_W'(BLINK_RST);
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (div_wr) begin
            blink_div <= bus.writedata[BLINK_W-1:0];
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_div == '0) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == (blink_div - BLINK_W'(1))) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Stage p0: logical segments from current register state
    always_comb begin
        seg_p0 = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_p0[7*i +: 7] = mode[i] ? hex7(hexval[4*i +: 4]) : raw[i];
            if (blink_en[i] && !phase) seg_p0[7*i +: 7] = 7'h00;
        end
    end

    // Stage p1: polarity-adjusted pins registered every clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_port <= PIN_OFF;
        else          out_port <= seg_p0 ^ PIN_OFF;
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            4'd0: begin
                rd_data[7:0]  = 8'(mode);
                rd_data[15:8] = 8'(blink_en);
            end
            4'd1: rd_data = 32'(hexval);
            4'd2: rd_data = 32'(blink_div);
            4'd3: rd_data[0] = phase;
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (bus.address == 4'(8 + i)) rd_data[6:0] = raw[i];
            end
        endcase
    end

    assign bus.readdata = rd_data;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed register-map table, blink corner
// sequences and a randomized run against an arithmetic reference model.
module tb_hex_display_ctrl;

    localparam int ND    = 6;
    localparam int OW    = ND * 7;
    localparam int DIV_R = 25000000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [OW-1:0] out_port;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    hex_display_if bus ();

    hex_display_ctrl #(
        .NUM_DIGITS(ND),
        .ACTIVE_LOW(1),
        .BLINK_W(26),
        .BLINK_RST(DIV_R)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register contents plus edges elapsed since the divider restarted.
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [ND-1:0]   m_mode;
    logic [ND-1:0]   m_en;
    logic [4*ND-1:0] m_hex;
    logic [25:0]     m_div;
    logic [6:0]      m_raw [ND];
    longint          m_k;
    logic [OW-1:0]   exp_out;

    function automatic logic m_phase();
        if (m_div == 26'd0) return 1'b1;
        return ((m_k / longint'(m_div)) % 2) == 0;
    endfunction

    function automatic logic [OW-1:0] m_pins();
        logic [OW-1:0] p;
        logic [6:0]    s;
        p = '0;
        for (int i = 0; i < ND; i++) begin
            s = m_mode[i] ? HEX[m_hex[4*i +: 4]] : m_raw[i];
            if (m_en[i] && !m_phase()) s = 7'h00;
            p[7*i +: 7] = ~s;
        end
        return p;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int ia;
        ia = int'(a);
        case (ia)
            0: return {16'h0, 2'b0, m_en, 2'b0, m_mode};
            1: return {8'h0, m_hex};
            2: return {6'h0, m_div};
            3: return {31'h0, m_phase()};
            default: return (ia >= 8 && ia < 8 + ND) ? {25'h0, m_raw[ia-8]} : 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  <= '0;
            m_en    <= '0;
            m_hex   <= '0;
            m_div   <= 26'(DIV_R);
            m_k     <= 0;
            exp_out <= '1;
            for (int i = 0; i < ND; i++) m_raw[i] <= '0;
        end else begin
            exp_out <= m_pins();
            m_k     <= m_k + 1;
            if (bus.chipselect && !bus.write_n) begin
                case (int'(bus.address))
                    0: begin
                        m_mode <= bus.writedata[ND-1:0];
                        m_en   <= bus.writedata[8 +: ND];
                    end
                    1: m_hex <= bus.writedata[4*ND-1:0];
                    2: begin
                        m_div <= bus.writedata[25:0];
                        m_k   <= 0;
                    end
                    default: if (int'(bus.address) >= 8 && int'(bus.address) < 8 + ND)
                        m_raw[int'(bus.address) - 8] <= bus.writedata[6:0];
                endcase
            end
        end
    end

    always @(negedge clk) chk("out_port_model", 64'(out_port), 64'(exp_out));

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] e);
        bus.address = a;
        #1;
        chk(name, 64'(bus.readdata), 64'(e));
    endtask

    function automatic logic [OW-1:0] pk(input logic [6:0] d0, d1, d2, d3, d4, d5);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    typedef struct {
        logic [3:0]    addr;
        logic [31:0]   wdata;
        logic [31:0]   rd;
        logic [OW-1:0] out;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'd0,  32'h0000003F, 32'h0000003F, pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)};
        tbl[1] = '{4'd1,  32'h0000A5F3, 32'h0000A5F3, pk(7'h30, 7'h0E, 7'h12, 7'h08, 7'h40, 7'h40)};
        tbl[2] = '{4'd1,  32'hFFFFFFFF, 32'h00FFFFFF, pk(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E)};
        tbl[3] = '{4'd0,  32'h00000000, 32'h00000000, pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)};
        tbl[4] = '{4'd10, 32'h00000049, 32'h00000049, pk(7'h7F, 7'h7F, 7'h36, 7'h7F, 7'h7F, 7'h7F)};
        tbl[5] = '{4'd14, 32'h0000007F, 32'h00000000, pk(7'h7F, 7'h7F, 7'h36, 7'h7F, 7'h7F, 7'h7F)};
        tbl[6] = '{4'd5,  32'h12345678, 32'h00000000, pk(7'h7F, 7'h7F, 7'h36, 7'h7F, 7'h7F, 7'h7F)};
        tbl[7] = '{4'd8,  32'h000000FF, 32'h0000007F, pk(7'h00, 7'h7F, 7'h36, 7'h7F, 7'h7F, 7'h7F)};
        tbl[8] = '{4'd0,  32'hFFFFFF04, 32'h00003F04, pk(7'h00, 7'h7F, 7'h0E, 7'h7F, 7'h7F, 7'h7F)};
        tbl[9] = '{4'd0,  32'h00000000, 32'h00000000, pk(7'h00, 7'h7F, 7'h36, 7'h7F, 7'h7F, 7'h7F)};

        bus.address    = 4'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        // Power-on reset values
        repeat (3) @(negedge clk);
        chk("reset_out", 64'(out_port), 64'({OW{1'b1}}));
        rd_chk("reset_ctrl", 4'd0, 32'h0);
        rd_chk("reset_div", 4'd2, 32'(DIV_R));
        rd_chk("reset_status", 4'd3, 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Register map / decode table
        for (int i = 0; i < 10; i++) begin
            bus_write(tbl[i].addr, tbl[i].wdata);
            rd_chk($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].rd);
            @(negedge clk);
            chk($sformatf("tbl%0d_out", i), 64'(out_port), 64'(tbl[i].out));
        end

        // Write-to-pin latency: unchanged right after the write edge, updated one edge later
        bus_write(4'd11, 32'h06);
        chk("latency_before", 64'(out_port[27:21]), 64'(7'h7F));
        @(negedge clk);
        chk("latency_after", 64'(out_port[27:21]), 64'(7'h79));

        // Reset asserted mid-count with phase low
        bus_write(4'd0, 32'h3F);
        bus_write(4'd2, 32'd3);
        repeat (3) @(negedge clk);
        rd_chk("premid_status", 4'd3, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("midreset_out", 64'(out_port), 64'({OW{1'b1}}));
        rd_chk("midreset_ctrl", 4'd0, 32'h0);
        rd_chk("midreset_div", 4'd2, 32'(DIV_R));
        rd_chk("midreset_status", 4'd3, 32'h1);
        rd_chk("midreset_raw3", 4'd11, 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Blink with divider 4 on digit 0 only
        bus_write(4'd0, 32'h0100);
        bus_write(4'd8, 32'h7F);
        bus_write(4'd9, 32'h06);
        bus_write(4'd2, 32'd4);
        for (int j = 0; j < 16; j++) begin
            rd_chk("blink_status", 4'd3, 32'(((j / 4) % 2) == 0));
            if (j >= 1)
                chk("blink_d0", 64'(out_port[6:0]), (((j - 1) / 4) % 2 == 0) ? 64'h00 : 64'h7F);
            chk("blink_d1", 64'(out_port[13:7]), 64'h79);
            @(negedge clk);
        end

        // Divider write on the wrap edge wins: phase stays visible, count restarts
        bus_write(4'd2, 32'd4);
        repeat (3) @(negedge clk);
        bus.address    = 4'd2;
        bus.writedata  = 32'd3;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        for (int t = 0; t < 4; t++) begin
            rd_chk("wrap_prio_status", 4'd3, 32'(t < 3));
            @(negedge clk);
        end

        // Divider 0 freezes phase visible
        bus_write(4'd2, 32'd0);
        for (int j = 0; j < 8; j++) begin
            rd_chk("div0_status", 4'd3, 32'h1);
            if (j >= 1) chk("div0_d0", 64'(out_port[6:0]), 64'h00);
            @(negedge clk);
        end

        // Unmapped address and write without chipselect
        bus_write(4'd5, 32'hDEADBEEF);
        rd_chk("unmapped_rd", 4'd5, 32'h0);
        rd_chk("unmapped_ctrl", 4'd0, 32'h0100);
        @(negedge clk);
        bus.address    = 4'd0;
        bus.writedata  = 32'h0000FFFF;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.write_n    = 1'b1;
        rd_chk("nocs_ctrl", 4'd0, 32'h0100);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            bus.address    = a;
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = 1'($urandom_range(0, 1));
            bus.writedata  = (a == 4'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            @(negedge clk);
            #1 chk("rand_rd", 64'(bus.readdata), 64'(m_read(bus.address)));
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
